// File: rtl/memory_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memory_arbiter_pkg
// Brief    : Shared state encoding, Memory_IO op-select codes and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package memory_arbiter_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ISSUE    = 2'd1;
    localparam logic [1:0] ST_WAIT     = 2'd2;
    localparam logic [1:0] ST_COMPLETE = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        ISSUE    = ST_ISSUE,
        WAIT     = ST_WAIT,
        COMPLETE = ST_COMPLETE
    } arb_state_t;

    // Memory_IO transfer direction codes, shared with Memory_IO and its clients
    localparam logic [1:0] OP_FILE2MEM = 2'b00;
    localparam logic [1:0] OP_MEM2FILE = 2'b01;
    localparam logic [1:0] OP_BUS2MEM  = 2'b10;
    localparam logic [1:0] OP_MEM2BUS  = 2'b11;

    localparam int MAX_REQ = 8;

    function automatic int onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (onehot[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/memory_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : memory_arbiter_if
// Brief    : Requester-side and Memory_IO-side signal bundle of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface memory_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int BUS_WIDTH = 32
);

    logic [NUM_REQ-1:0]           Arb_Req;
    logic [2*NUM_REQ-1:0]         Arb_Op;
    logic [BUS_WIDTH*NUM_REQ-1:0] Arb_Addr;
    logic [BUS_WIDTH*NUM_REQ-1:0] Arb_Words;
    logic [NUM_REQ-1:0]           Arb_Gnt;
    logic [NUM_REQ-1:0]           Arb_Done;
    logic [NUM_REQ-1:0]           Arb_Err;
    logic                         Arb_Busy;
    logic [1:0]                   Mem_Req_Sel;
    logic                         Mem_En;
    logic [BUS_WIDTH-1:0]         Mem_Start_Addr;
    logic [BUS_WIDTH-1:0]         Mem_Words;
    logic                         Mem_DNE;

    // master: the arbiter itself; slave: requesters plus Memory_IO
    modport master (
        input  Arb_Req, Arb_Op, Arb_Addr, Arb_Words, Mem_DNE,
        output Arb_Gnt, Arb_Done, Arb_Err, Arb_Busy,
               Mem_Req_Sel, Mem_En, Mem_Start_Addr, Mem_Words
    );

    modport slave (
        output Arb_Req, Arb_Op, Arb_Addr, Arb_Words, Mem_DNE,
        input  Arb_Gnt, Arb_Done, Arb_Err, Arb_Busy,
               Mem_Req_Sel, Mem_En, Mem_Start_Addr, Mem_Words
    );

endinterface
`default_nettype wire

// File: rtl/memory_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational rotate-priority picker, first set bit at or above ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [PTR_W-1:0]   i_ptr,
    output logic      [NUM_REQ-1:0] o_pick,
    output logic                    o_valid
);

    logic w_found;

    // Upper segment [ptr, NUM_REQ-1] first, then wrap to [0, ptr-1]
    always_comb begin
        o_pick  = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req[i] && (i >= int'(i_ptr))) begin
                o_pick[i] = 1'b1;
                w_found   = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req[i] && (i < int'(i_ptr))) begin
                o_pick[i] = 1'b1;
                w_found   = 1'b1;
            end
        end
    end

    assign o_valid = |i_req;

endmodule
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_arbiter
// Brief    : Round-robin owner of the single Memory_IO port with done timeout.
// Revision : 1.0 - initial release
// ============================================================================
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BUS_WIDTH = 32,
    parameter int TIMEOUT   = 1024
) (
    input  wire logic         Arb_Clk,
    input  wire logic         Arb_Reset,
    memory_arbiter_if.master  bus
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(NUM_REQ - 1);

    arb_state_t           r_state;
    logic [PTR_W-1:0]     r_ptr;
    logic [CNT_W-1:0]     r_cnt;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_done;
    logic [NUM_REQ-1:0]   r_err;
    logic                 r_busy;
    logic                 r_mem_en;
    logic [1:0]           r_mem_sel;
    logic [BUS_WIDTH-1:0] r_mem_addr;
    logic [BUS_WIDTH-1:0] r_mem_words;

    logic [NUM_REQ-1:0]   w_pick;
    logic                 w_valid;
    logic [1:0]           w_sel;
    logic [BUS_WIDTH-1:0] w_addr;
    logic [BUS_WIDTH-1:0] w_words;
    logic [PTR_W-1:0]     w_gidx;
    logic [PTR_W-1:0]     w_ptr_next;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .i_req   (bus.Arb_Req),
        .i_ptr   (r_ptr),
        .o_pick  (w_pick),
        .o_valid (w_valid)
    );

    // One-hot mux of the winning requester's transfer descriptor
    always_comb begin
        w_sel   = '0;
        w_addr  = '0;
        w_words = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick[i]) begin
                w_sel   = bus.Arb_Op[2*i +: 2];
                w_addr  = bus.Arb_Addr[BUS_WIDTH*i +: BUS_WIDTH];
                w_words = bus.Arb_Words[BUS_WIDTH*i +: BUS_WIDTH];
            end
        end
    end

    assign w_gidx     = PTR_W'(onehot_to_idx(MAX_REQ'(r_gnt)));
    assign w_ptr_next = (w_gidx == C_PTR_LAST) ? '0 : (w_gidx + 1'b1);

    always_ff @(posedge Arb_Clk) begin
        if (Arb_Reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_err       <= '0;
            r_busy      <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_sel   <= '0;
            r_mem_addr  <= '0;
            r_mem_words <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_gnt       <= w_pick;
                        r_mem_sel   <= w_sel;
                        r_mem_addr  <= w_addr;
                        r_mem_words <= w_words;
                        r_mem_en    <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // A done strobe on the final counted cycle still counts as success
                    if (bus.Mem_DNE) begin
                        r_done   <= r_gnt;
                        r_mem_en <= 1'b0;
                        r_state  <= COMPLETE;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_err    <= r_gnt;
                        r_mem_en <= 1'b0;
                        r_state  <= COMPLETE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                COMPLETE: begin
                    r_done  <= '0;
                    r_err   <= '0;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= w_ptr_next;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Arb_Gnt        = r_gnt;
    assign bus.Arb_Done       = r_done;
    assign bus.Arb_Err        = r_err;
    assign bus.Arb_Busy       = r_busy;
    assign bus.Mem_En         = r_mem_en;
    assign bus.Mem_Req_Sel    = r_mem_sel;
    assign bus.Mem_Start_Addr = r_mem_addr;
    assign bus.Mem_Words      = r_mem_words;

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_arbiter
// Brief    : Self-checking bench for memory_arbiter (4 requesters, TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int BW = 32;
    localparam int TO = 8;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   m_ptr;
    int   last_gnt_cyc;

    memory_arbiter_if #(.NUM_REQ(N), .BUS_WIDTH(BW)) bus ();

    memory_arbiter #(
        .NUM_REQ   (N),
        .BUS_WIDTH (BW),
        .TIMEOUT   (TO)
    ) dut (
        .Arb_Clk   (clk),
        .Arb_Reset (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  req;
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] words;
        int          dne_at;   // WAIT cycle with done strobe, 0 = never
        bit          drop;
        bit          b2b;
        logic [3:0]  exp_gnt;
        bit          exp_ok;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: first requesting index at or after ptr, wrapping around
    function automatic logic [3:0] rr_model(input logic [3:0] req, input int ptr);
        logic [3:0] res;
        bit found;
        int idx;
        res = '0;
        found = 0;
        for (int k = 0; k < N; k++) begin
            idx = (ptr + k) % N;
            if (!found && req[idx[1:0]]) begin
                res = 4'(1 << idx);
                found = 1;
            end
        end
        return res;
    endfunction

    function automatic logic [79:0] all_outs();
        return {bus.Arb_Gnt, bus.Arb_Done, bus.Arb_Err, bus.Arb_Busy, bus.Mem_Req_Sel,
                bus.Mem_En, bus.Mem_Start_Addr, bus.Mem_Words};
    endfunction

    function automatic logic [13:0] ctl_outs();
        return {bus.Arb_Gnt, bus.Mem_En, bus.Arb_Busy, bus.Arb_Done, bus.Arb_Err};
    endfunction

    // Called at #1 after an edge with the DUT in IDLE; returns likewise.
    task automatic run_txn(input logic [3:0] req, input logic [1:0] op, input logic [31:0] addr,
                           input logic [31:0] words, input int dne_at, input bit drop, input bit b2b,
                           input logic [3:0] exp_gnt, input bit exp_ok, input string tag);
        int w;
        int last;
        logic [7:0]   opv;
        logic [127:0] av;
        logic [127:0] wv;
        logic [65:0]  fld;
        w = 0;
        for (int i = 0; i < N; i++) begin
            if (exp_gnt[i]) w = i;
            opv[2*i +: 2] = 2'($urandom);
            av[32*i +: 32] = $urandom;
            wv[32*i +: 32] = $urandom;
        end
        opv[2*w +: 2]  = op;
        av[32*w +: 32] = addr;
        wv[32*w +: 32] = words;
        fld = {op, addr, words};
        bus.Arb_Req   = req;
        bus.Arb_Op    = opv;
        bus.Arb_Addr  = av;
        bus.Arb_Words = wv;
        bus.Mem_DNE   = 1'b0;

        @(posedge clk); #1;
        chk({tag, " issue ctl"}, 128'(ctl_outs()), 128'({exp_gnt, 1'b1, 1'b1, 4'b0, 4'b0}));
        chk({tag, " issue fields"}, 128'({bus.Mem_Req_Sel, bus.Mem_Start_Addr, bus.Mem_Words}), 128'(fld));
        if (b2b) chk({tag, " grant spacing"}, 128'(cyc - last_gnt_cyc), 128'(4));
        last_gnt_cyc = cyc;
        bus.Mem_DNE = 1'($urandom);   // must be ignored while issuing

        last = (dne_at >= 1 && dne_at <= TO) ? dne_at : TO;
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            bus.Mem_DNE = (c == dne_at);
            if (drop && c == 1) begin
                bus.Arb_Req   = '0;
                bus.Arb_Op    = ~opv;
                bus.Arb_Addr  = ~av;
                bus.Arb_Words = ~wv;
            end
            chk($sformatf("%s wait%0d ctl", tag, c), 128'(ctl_outs()),
                128'({exp_gnt, 1'b1, 1'b1, 4'b0, 4'b0}));
        end

        @(posedge clk); #1;
        bus.Mem_DNE = 1'b0;
        chk({tag, " complete ctl"}, 128'(ctl_outs()),
            128'({exp_gnt, 1'b0, 1'b1, (exp_ok ? exp_gnt : 4'b0), (exp_ok ? 4'b0 : exp_gnt)}));
        chk({tag, " complete fields"}, 128'({bus.Mem_Req_Sel, bus.Mem_Start_Addr, bus.Mem_Words}), 128'(fld));

        @(posedge clk); #1;
        chk({tag, " idle ctl"}, 128'(ctl_outs()), 128'(0));
        chk({tag, " idle fields"}, 128'({bus.Mem_Req_Sel, bus.Mem_Start_Addr, bus.Mem_Words}), 128'(fld));
        m_ptr = (w + 1) % N;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] r;
        logic [3:0] g;
        int d;
        n_checks = 0;
        n_fail = 0;
        m_ptr = 0;
        last_gnt_cyc = 0;

        //           req      op           addr          words         dne drop b2b gnt      ok
        tbl[0]  = '{4'b1111, OP_FILE2MEM, 32'h0000_1000, 32'd16,       1, 1'b0, 1'b0, 4'b0001, 1'b1};
        tbl[1]  = '{4'b1111, OP_MEM2FILE, 32'h0000_2000, 32'd17,       1, 1'b0, 1'b1, 4'b0010, 1'b1};
        tbl[2]  = '{4'b1111, OP_BUS2MEM,  32'h0000_3000, 32'd18,       1, 1'b0, 1'b1, 4'b0100, 1'b1};
        tbl[3]  = '{4'b1111, OP_MEM2BUS,  32'h0000_4000, 32'd19,       1, 1'b0, 1'b1, 4'b1000, 1'b1};
        tbl[4]  = '{4'b1111, OP_FILE2MEM, 32'h0000_5000, 32'd20,       1, 1'b0, 1'b1, 4'b0001, 1'b1};
        tbl[5]  = '{4'b0010, OP_BUS2MEM,  32'h0000_0100, 32'd64,       3, 1'b0, 1'b0, 4'b0010, 1'b1};
        tbl[6]  = '{4'b1000, OP_MEM2BUS,  32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 4'b1000, 1'b0};
        tbl[7]  = '{4'b0101, OP_MEM2FILE, 32'h0000_1234, 32'd5,        8, 1'b0, 1'b0, 4'b0001, 1'b1};
        tbl[8]  = '{4'b0101, OP_BUS2MEM,  32'h0000_ABCD, 32'd6,        9, 1'b0, 1'b0, 4'b0100, 1'b0};
        tbl[9]  = '{4'b0011, OP_FILE2MEM, 32'h0000_0777, 32'd7,        2, 1'b1, 1'b0, 4'b0001, 1'b1};
        tbl[10] = '{4'b1001, OP_MEM2BUS,  32'h0000_CAFE, 32'd8,        5, 1'b0, 1'b0, 4'b1000, 1'b1};
        tbl[11] = '{4'b1110, OP_MEM2FILE, 32'h0000_BEEF, 32'd9,        1, 1'b0, 1'b0, 4'b0010, 1'b1};

        rst = 1'b1;
        bus.Arb_Req   = 4'b1111;
        bus.Arb_Op    = '0;
        bus.Arb_Addr  = '1;
        bus.Arb_Words = '1;
        bus.Mem_DNE   = 1'b1;
        @(posedge clk); #1;
        chk("reset outputs 1", 128'(all_outs()), 128'(0));
        @(posedge clk); #1;
        chk("reset outputs 2", 128'(all_outs()), 128'(0));
        rst = 1'b0;
        bus.Mem_DNE = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_txn(tbl[i].req, tbl[i].op, tbl[i].addr, tbl[i].words, tbl[i].dne_at, tbl[i].drop,
                    tbl[i].b2b, tbl[i].exp_gnt, tbl[i].exp_ok, $sformatf("row%0d", i));
        end

        // Reset in the middle of a WAIT, with another request pending
        bus.Arb_Req = 4'b0100;
        @(posedge clk); #1;
        chk("pre-reset grant", 128'(bus.Arb_Gnt), 128'(rr_model(4'b0100, m_ptr)));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.Arb_Req = 4'b0001;
        @(posedge clk); #1;
        chk("mid-transfer reset outputs", 128'(all_outs()), 128'(0));
        @(posedge clk); #1;
        chk("held reset outputs", 128'(all_outs()), 128'(0));
        rst = 1'b0;
        m_ptr = 0;
        run_txn(4'b0001, OP_MEM2BUS, 32'h0000_0040, 32'd3, 1, 1'b0, 1'b0, 4'b0001, 1'b1, "post-reset");

        for (int t = 0; t < 60; t++) begin
            r = 4'($urandom_range(1, 15));
            d = $urandom_range(0, TO + 1);
            g = rr_model(r, m_ptr);
            run_txn(r, 2'($urandom), $urandom, $urandom, d, 1'($urandom), 1'b0, g,
                    (d >= 1 && d <= TO), $sformatf("rand%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
